// File: rtl/toy_bus_pkg.sv
// Shared ToyBusReq definitions: field widths, opcode values and the packed request payload.
package toy_bus_pkg;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned STRB_W = DW / 8;
    localparam int unsigned IDW    = 4;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef struct packed {
        logic [AW-1:0]     addr;
        logic [STRB_W-1:0] strb;
        logic [DW-1:0]     data;
        logic              opcode;
        logic [IDW-1:0]    src_id;
        logic [IDW-1:0]    tgt_id;
    } toy_bus_req_t;

endpackage

// File: rtl/toy_bus_arb_rr_req_slice_if.sv
// N-input request bundle plus the single merged output port of the round-robin slice.
interface toy_bus_arb_rr_req_slice_if #(
    parameter int unsigned N_IN = 2
);
    import toy_bus_pkg::*;

    localparam int unsigned PW = $clog2(N_IN);

    logic [N_IN-1:0]        in_vld;
    logic [N_IN-1:0]        in_rdy;
    logic [N_IN*AW-1:0]     in_addr;
    logic [N_IN*STRB_W-1:0] in_strb;
    logic [N_IN*DW-1:0]     in_data;
    logic [N_IN-1:0]        in_opcode;
    logic [N_IN*IDW-1:0]    in_src_id;
    logic [N_IN*IDW-1:0]    in_tgt_id;

    logic                   out_vld;
    logic                   out_rdy;
    logic [AW-1:0]          out_addr;
    logic [STRB_W-1:0]      out_strb;
    logic [DW-1:0]          out_data;
    logic                   out_opcode;
    logic [IDW-1:0]         out_src_id;
    logic [IDW-1:0]         out_tgt_id;
    logic [PW-1:0]          grant_idx;

    // Requesters and downstream consumer
    modport master (
        output in_vld, in_addr, in_strb, in_data, in_opcode, in_src_id, in_tgt_id, out_rdy,
        input  in_rdy, out_vld, out_addr, out_strb, out_data, out_opcode, out_src_id,
               out_tgt_id, grant_idx
    );

    // Arbiter side
    modport slave (
        input  in_vld, in_addr, in_strb, in_data, in_opcode, in_src_id, in_tgt_id, out_rdy,
        output in_rdy, out_vld, out_addr, out_strb, out_data, out_opcode, out_src_id,
               out_tgt_id, grant_idx
    );

endinterface

// File: rtl/toy_bus_rr_pick.sv
// Combinational round-robin pick: rotate valids by ptr, take lowest set bit, rotate index back.
module toy_bus_rr_pick #(
    parameter int unsigned N_IN = 2
) (
    input  logic [N_IN-1:0]         vld,
    input  logic [$clog2(N_IN)-1:0] ptr,
    output logic [$clog2(N_IN)-1:0] gnt_idx,
    output logic                    any
);

    localparam int unsigned PW = $clog2(N_IN);
    localparam int unsigned SW = PW + 1;

    logic [2*N_IN-2:0] dbl;
    logic [N_IN-1:0]   rot;
    logic [SW-1:0]     pos;
    logic [SW-1:0]     sum;

    always_comb begin
        dbl = {vld[N_IN-2:0], vld};
        rot = dbl[ptr +: N_IN];
        pos = '0;
        // Scan downward so the lowest rotated position wins
        for (int i = int'(N_IN) - 1; i >= 0; i--) begin
            if (rot[i]) pos = SW'(i);
        end
        sum     = SW'(ptr) + pos;
        gnt_idx = (sum >= SW'(N_IN)) ? PW'(sum - SW'(N_IN)) : PW'(sum);
    end

    assign any = |vld;

endmodule

// File: rtl/toy_bus_arb_rr_req_slice.sv
// N-to-1 round-robin merge of ToyBusReq beats into a registered forward output slice.
module toy_bus_arb_rr_req_slice
    import toy_bus_pkg::*;
#(
    parameter int unsigned N_IN = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    toy_bus_arb_rr_req_slice_if.slave   bus
);

    localparam int unsigned PW = $clog2(N_IN);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] rr_ptr_nxt;
    logic [PW-1:0] grant_q;
    logic          any_req;
    logic          load_ok;
    logic          hs;
    logic          out_vld_q;
    toy_bus_req_t  req_sel;
    toy_bus_req_t  out_q;

    toy_bus_rr_pick #(.N_IN(N_IN)) u_pick (
        .vld     (bus.in_vld),
        .ptr     (rr_ptr),
        .gnt_idx (gnt),
        .any     (any_req)
    );

    // Reset gating keeps every in_rdy low while rst_n is asserted
    assign load_ok    = !out_vld_q || bus.out_rdy;
    assign hs         = rst_n && load_ok && any_req;
    assign rr_ptr_nxt = (gnt == PW'(N_IN - 1)) ? '0 : gnt + PW'(1);

    always_comb begin
        bus.in_rdy = '0;
        if (hs) bus.in_rdy[gnt] = 1'b1;
    end

    // Granted input's payload, unpacked from the flat per-field buses
    always_comb begin
        req_sel.addr   = bus.in_addr  [int'(gnt)*AW     +: AW];
        req_sel.strb   = bus.in_strb  [int'(gnt)*STRB_W +: STRB_W];
        req_sel.data   = bus.in_data  [int'(gnt)*DW     +: DW];
        req_sel.opcode = bus.in_opcode[gnt];
        req_sel.src_id = bus.in_src_id[int'(gnt)*IDW    +: IDW];
        req_sel.tgt_id = bus.in_tgt_id[int'(gnt)*IDW    +: IDW];
    end

    // A handshake overrides a same-cycle pop, so the new beat replaces the old without a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
            grant_q   <= '0;
            rr_ptr    <= '0;
        end else if (hs) begin
            out_vld_q <= 1'b1;
            out_q     <= req_sel;
            grant_q   <= gnt;
            rr_ptr    <= rr_ptr_nxt;
        end else if (out_vld_q && bus.out_rdy) begin
            out_vld_q <= 1'b0;
        end
    end

    assign bus.out_vld    = out_vld_q;
    assign bus.out_addr   = out_q.addr;
    assign bus.out_strb   = out_q.strb;
    assign bus.out_data   = out_q.data;
    assign bus.out_opcode = out_q.opcode;
    assign bus.out_src_id = out_q.src_id;
    assign bus.out_tgt_id = out_q.tgt_id;
    assign bus.grant_idx  = grant_q;

endmodule
